// File: rtl/keypad_debouncer_n.sv
// Multi-channel keypad debouncer: per-channel two-flop synchroniser, stability counter,
// debounced level and registered single-cycle press/release pulses.
module keypad_debouncer_n #(
   parameter int unsigned         CHANNELS         = 4,
   parameter int unsigned         DEBOUNCE_DIVIDER = 2_400_000,
   parameter logic [CHANNELS-1:0] INVERT           = {CHANNELS{1'b0}},
   parameter int unsigned         CNT_W            = $clog2(DEBOUNCE_DIVIDER)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [CHANNELS-1:0] s_in,
   output logic [CHANNELS-1:0] s_out,
   output logic [CHANNELS-1:0] rise,
   output logic [CHANNELS-1:0] fall,
   output logic [CHANNELS-1:0] busy,
   output logic                any_active
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_DIVIDER - 1);

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      logic             r_sync1;
      logic             r_sync2;
      logic             r_out;
      logic             r_rise;
      logic             r_fall;
      logic [CNT_W-1:0] r_cnt;

      always_ff @(posedge clk or negedge reset) begin
         if (!reset) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_out   <= 1'b0;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            r_cnt   <= '0;
         end else begin
            // NOTE: non-blocking so sync1->sync2 and the counter all use pre-edge values.
            r_sync1 <= s_in[g] ^ INVERT[g];
            r_sync2 <= r_sync1;
            r_rise  <= 1'b0;
            r_fall  <= 1'b0;
            if (r_sync2 == r_out) begin
               r_cnt <= '0;
            end else if (r_cnt == CNT_MAX) begin
               // Level accepted: flip the output and fire the matching pulse on the same edge.
               r_out  <= r_sync2;
               r_rise <= r_sync2;
               r_fall <= ~r_sync2;
               r_cnt  <= '0;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end
      end

      assign s_out[g] = r_out;
      assign rise[g]  = r_rise;
      assign fall[g]  = r_fall;
      assign busy[g]  = (r_cnt != '0);
   end

   assign any_active = |s_out;

endmodule
